// File: rtl/hps_file_io_if.sv
// HPS file-transfer bus after the main command decoder has split it out:
// enable/strobe/data towards the engine, wait back towards the HPS.
interface hps_file_io_if;
  logic        io_enable;
  logic        io_strobe;
  logic [15:0] io_din;
  logic        io_wait;

  modport master (output io_enable, io_strobe, io_din, input io_wait);
  modport slave  (input io_enable, io_strobe, io_din, output io_wait);
endinterface

// File: rtl/hps_file_io.sv
// ARM-to-FPGA file transfer engine: command decode, data FIFO, ioctl drain and memory erase.
// Optional HPS_FILE_LOADADDR_EN: for a non-zero file index the first 16 data bits set the load address.
module hps_file_io #(
  parameter int DW         = 8,
  parameter int AW         = 25,
  parameter int FIFO_DEPTH = 4,
  parameter int ERASE_END  = 'h10000,
  parameter int ERASE_VAL  = 0
) (
  input  logic          clk_sys,
  input  logic          reset,
  hps_file_io_if.slave  hps,
  input  logic          ioctl_force_erase,
  input  logic          ioctl_wait,
  output logic          ioctl_download,
  output logic          ioctl_erasing,
  output logic [7:0]    ioctl_index,
  output logic          ioctl_wr,
  output logic [AW-1:0] ioctl_addr,
  output logic [DW-1:0] ioctl_dout,
  output logic          ioctl_ovf
);

  localparam int            PW         = $clog2(FIFO_DEPTH);
  localparam logic [PW:0]   CNT_FULL   = (PW+1)'(FIFO_DEPTH);
  localparam logic [PW:0]   CNT_WAIT   = (PW+1)'(FIFO_DEPTH - 1);
  localparam logic [AW-1:0] STEP       = AW'(DW / 8);
  localparam logic [AW-1:0] ERASE_LAST = AW'(ERASE_END - DW / 8);
  localparam logic [1:0]    HDR_WORDS  = (DW == 8) ? 2'd2 : 2'd1;
`ifdef HPS_FILE_LOADADDR_EN
  localparam bit LOADADDR_EN = 1'b1;
`else
  localparam bit LOADADDR_EN = 1'b0;
`endif

  // state | meaning
  // IDLE  | no transfer, no erase
  // LOAD  | download active, FIFO drained to ioctl
  // DRAIN | end requested, waiting for FIFO and last write
  // ERASE | erase writes in progress
  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, ERASE} state_t;
  state_t state, state_next;

  logic          has_cmd;
  logic [15:0]   cmd;
  logic          arg_stb, start, end_req, push_stb;
  logic          push_req;
  logic [DW-1:0] push_data;
  logic [DW-1:0] fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   fifo_cnt;
  logic          fifo_full, pop, push_ok;
  logic [DW-1:0] pop_word;
  logic [15:0]   pop_word16;
  logic [AW-1:0] addr_cnt;
  logic [1:0]    hdr_left;
  logic [7:0]    hdr_lo;
  logic          erase_prev, erase_req, erase_last, erase_fire;
  logic [1:0]    erase_tmr;
  logic [AW-1:0] erase_addr;

  assign arg_stb   = hps.io_enable && hps.io_strobe && has_cmd;
  assign start     = arg_stb && (cmd == 16'h0053) && (hps.io_din[7:0] != 8'h00);
  assign end_req   = arg_stb && (cmd == 16'h0053) && (hps.io_din[7:0] == 8'h00);
  assign push_stb  = arg_stb && (cmd == 16'h0054);
  assign erase_req = ioctl_force_erase && !erase_prev;

  assign ioctl_download = (state == LOAD) || (state == DRAIN);
  assign ioctl_erasing  = (state == ERASE);
  assign hps.io_wait    = (fifo_cnt >= CNT_WAIT) || ioctl_erasing;

  assign fifo_full  = (fifo_cnt == CNT_FULL);
  assign pop        = ioctl_download && (fifo_cnt != '0) && !ioctl_wait && !ioctl_wr;
  assign push_ok    = push_req && (!fifo_full || pop);
  assign pop_word   = fifo_mem[rd_ptr];
  assign pop_word16 = 16'(pop_word);
  assign erase_fire = ioctl_erasing && (erase_tmr == 2'd0) && !ioctl_wait && !erase_last;

  always_ff @(posedge clk_sys) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start)          state_next = LOAD;
        else if (erase_req) state_next = ERASE;
      end
      LOAD: begin
        if (end_req) state_next = DRAIN;
      end
      DRAIN: begin
        if (start) state_next = LOAD;
        else if ((fifo_cnt == '0) && !push_req && !ioctl_wr) state_next = IDLE;
      end
      ERASE: begin
        if (start)           state_next = LOAD;
        else if (erase_last) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      has_cmd     <= 1'b0;
      cmd         <= '0;
      ioctl_index <= '0;
      push_req    <= 1'b0;
      push_data   <= '0;
      erase_prev  <= 1'b0;
    end else begin
      erase_prev <= ioctl_force_erase;
      push_req   <= push_stb;
      if (push_stb) push_data <= hps.io_din[DW-1:0];
      if (!hps.io_enable) has_cmd <= 1'b0;
      else if (hps.io_strobe && !has_cmd) begin
        has_cmd <= 1'b1;
        cmd     <= hps.io_din;
      end
      if (arg_stb && (cmd == 16'h0055)) ioctl_index <= hps.io_din[7:0];
    end
  end

  // A download start flushes the FIFO, including a word still in the push stage.
  always_ff @(posedge clk_sys) begin
    if (reset || start) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      fifo_cnt  <= '0;
      ioctl_ovf <= 1'b0;
    end else begin
      if (push_ok)       wr_ptr    <= wr_ptr + PW'(1);
      else if (push_req) ioctl_ovf <= 1'b1;
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      fifo_cnt <= fifo_cnt + {{PW{1'b0}}, push_ok} - {{PW{1'b0}}, pop};
    end
  end

  always_ff @(posedge clk_sys) begin
    if (push_ok && !start && !reset) fifo_mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      ioctl_wr   <= 1'b0;
      ioctl_addr <= '0;
      ioctl_dout <= '0;
      addr_cnt   <= '0;
      hdr_left   <= '0;
      hdr_lo     <= '0;
      erase_tmr  <= '0;
      erase_addr <= '0;
      erase_last <= 1'b0;
    end else begin
      ioctl_wr <= 1'b0;
      if (pop) begin
        if (hdr_left == 2'd0) begin
          ioctl_wr   <= 1'b1;
          ioctl_addr <= addr_cnt;
          ioctl_dout <= pop_word;
          addr_cnt   <= addr_cnt + STEP;
        end else begin
          hdr_left <= hdr_left - 2'd1;
          if (hdr_left == 2'd2) hdr_lo   <= pop_word16[7:0];
          else if (DW == 8)     addr_cnt <= AW'({pop_word16[7:0], hdr_lo});
          else                  addr_cnt <= AW'(pop_word16);
        end
      end
      if (start) begin
        addr_cnt <= '0;
        hdr_left <= (LOADADDR_EN && (ioctl_index != 8'h00)) ? HDR_WORDS : 2'd0;
      end
      // Erase: one write per 4 cycles; the timer holds at zero while the core waits.
      if (!ioctl_erasing) begin
        erase_tmr  <= '0;
        erase_addr <= '0;
        erase_last <= 1'b0;
      end else if (erase_fire) begin
        ioctl_wr   <= 1'b1;
        ioctl_addr <= erase_addr;
        ioctl_dout <= DW'(ERASE_VAL);
        erase_addr <= erase_addr + STEP;
        erase_tmr  <= 2'd3;
        erase_last <= (erase_addr == ERASE_LAST);
      end else if (erase_tmr != 2'd0) begin
        erase_tmr <= erase_tmr - 2'd1;
      end
    end
  end

endmodule
